mem_stage_sequencer: RTL and testbench
======================================

# mem_stage_sequencer

Pipeline controller for the EXE/MEM boundary of the 5-stage MIPS core. It drives the data-memory request/acknowledge handshake for loads and stores held in the EXE/MEM register. While memory is outstanding it freezes the front of the pipeline and injects a bubble into MEM/WB. It also detects load-use hazards between ID/EXE and IF/ID, and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- CNT_W, 16, stall counter width
- TIMEOUT, 64, maximum WAIT_ACK cycles before error (used only with MEMSEQ_TIMEOUT_EN)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_id_rs, if_id_rt  in  5  source registers of the instruction in ID
- id_exe_memread  in  1  instruction in EXE is a load
- id_exe_rt  in  5  destination register of that load
- exe_mem_memread, exe_mem_memwrite  in  1  load/store held in the EXE/MEM register
- dmem_ack  in  1  data memory completes the access this cycle
- stall_clr  in  1  synchronous clear of stall_count
- dmem_req  out  1  data-memory access request
- pc_write, if_id_write  out  1  PC and IF/ID load enables
- id_exe_bubble  out  1  zero the control fields loaded into ID/EXE
- pipe_hold  out  1  freeze the ID/EXE and EXE/MEM registers
- mem_wb_bubble  out  1  zero the control fields loaded into MEM/WB
- stall_count  out  CNT_W  cycles with pc_write=0, saturating
- mem_timeout  out  1  sticky memory-timeout error

## Operation
- States: RUN, WAIT_ACK, and ERR (ERR exists only with the macro). Reset state is RUN.
- `access` = exe_mem_memread | exe_mem_memwrite.
- dmem_req = (RUN & access) | WAIT_ACK.
- Memory stall: `mstall` = dmem_req & ~dmem_ack, or state ERR.
  - When mstall=1: pipe_hold=1, pc_write=0, if_id_write=0, mem_wb_bubble=1, id_exe_bubble=0.
- Load-use hazard: id_exe_memread & (id_exe_rt != 0) & (id_exe_rt == if_id_rs | id_exe_rt == if_id_rt).
  - Applies only when mstall=0.
  - Response: pc_write=0, if_id_write=0, id_exe_bubble=1, pipe_hold=0.
- Otherwise: pc_write=1, if_id_write=1, and all other control outputs are 0.
- Transitions:
  - RUN → WAIT_ACK on access & ~dmem_ack.
  - RUN stays in RUN on zero-wait access (ack in the same cycle).
  - WAIT_ACK → RUN on dmem_ack. The ack cycle is the advance cycle, so pipe_hold=0 in that cycle.
- stall_count:
  - stall_clr → 0.
  - Else if pc_write=0 and not saturated at 2^CNT_W−1 → +1.
  - stall_clr has priority over the increment.
- While rst_n=0, all outputs are forced to their reset values regardless of inputs.

## Timing
- Reset values: state RUN, stall_count 0, wait counter 0, dmem_req 0, pc_write 1, if_id_write 1, id_exe_bubble 0, pipe_hold 0, mem_wb_bubble 0, mem_timeout 0.
- All control outputs are combinational from state and inputs, with no added latency. State and counters update on the rising clk edge.
- Zero-wait access adds 0 stall cycles. An access acked in cycle N of the request (N ≥ 1) adds N−1 stall cycles.
- A load-use hazard adds exactly 1 stall cycle. The bubble clears id_exe_memread on the following cycle.
- If a memory stall and a load-use hazard occur together, the memory stall wins. The hazard is re-evaluated after release.
- If reset asserts mid-WAIT_ACK, dmem_req drops immediately and the access is abandoned.

## Configuration
- MEMSEQ_TIMEOUT_EN defined:
  - A wait counter clears on entry to WAIT_ACK and counts WAIT_ACK cycles.
  - After TIMEOUT cycles in WAIT_ACK without ack, the FSM enters ERR.
  - An ack in the TIMEOUT-th cycle wins over the timeout.
  - In ERR: dmem_req=0, mstall=1 permanently, mem_timeout=1 until reset.
- MEMSEQ_TIMEOUT_EN undefined:
  - No wait counter and no ERR state; WAIT_ACK waits indefinitely.
  - mem_timeout is tied to 0.

## Test plan
- Reset: assert rst_n=0 with exe_mem_memread=1 → dmem_req=0, pc_write=1, stall_count=0.
- Zero-wait store: exe_mem_memwrite=1 with dmem_ack=1 in the same cycle → dmem_req=1, pipe_hold=0, state stays RUN, stall_count unchanged.
- 3-cycle load: exe_mem_memread=1, ack in the 3rd request cycle → pipe_hold=1 and mem_wb_bubble=1 for 2 cycles, release on the ack cycle, stall_count +2.
- Load-use: id_exe_memread=1, id_exe_rt=5, if_id_rt=5 → id_exe_bubble=1, pc_write=0 for exactly 1 cycle. The same case with id_exe_rt=0 → no stall.
- Simultaneous events and counter: load-use hazard during WAIT_ACK → id_exe_bubble=0 until ack, then 1 for one cycle. With CNT_W=4, 20 stall cycles → stall_count=15. stall_clr together with a stall cycle → 0.
- Timeout (macro on, TIMEOUT=4): no ack → ERR after 4 WAIT_ACK cycles, mem_timeout=1, dmem_req=0, pipe_hold stays 1 until rst_n=0.

Source files
------------

// File: rtl/mem_stage_sequencer.sv
// EXE/MEM data-memory handshake sequencer with load-use hazard detection and a saturating stall counter.
// Optional memory timeout / ERR state is enabled by defining MEMSEQ_TIMEOUT_EN.
module mem_stage_sequencer #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             id_exe_memread,
  input  logic [4:0]       id_exe_rt,
  input  logic             exe_mem_memread,
  input  logic             exe_mem_memwrite,
  input  logic             dmem_ack,
  input  logic             stall_clr,
  output logic             dmem_req,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_exe_bubble,
  output logic             pipe_hold,
  output logic             mem_wb_bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_timeout
);

  typedef enum logic [1:0] {
    RUN,
    WAIT_ACK
`ifdef MEMSEQ_TIMEOUT_EN
    , ERR
`endif
  } state_t;

  state_t state;
  logic   access;
  logic   req;
  logic   in_err;
  logic   mstall;
  logic   hazard;

`ifdef MEMSEQ_TIMEOUT_EN
  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [WAIT_W-1:0] wait_cnt;
`endif

  always_comb begin
    access = exe_mem_memread | exe_mem_memwrite;
    req    = ((state == RUN) & access) | (state == WAIT_ACK);
`ifdef MEMSEQ_TIMEOUT_EN
    in_err = (state == ERR);
`else
    in_err = 1'b0;
`endif
    mstall = (req & ~dmem_ack) | in_err;
    hazard = id_exe_memread & (id_exe_rt != 5'd0) &
             ((id_exe_rt == if_id_rs) | (id_exe_rt == if_id_rt));

    dmem_req      = 1'b0;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_exe_bubble = 1'b0;
    pipe_hold     = 1'b0;
    mem_wb_bubble = 1'b0;
    mem_timeout   = 1'b0;
    // Outputs are gated by rst_n so they sit at reset values for the whole reset window.
    if (rst_n) begin
      dmem_req    = req;
      mem_timeout = in_err;
      if (mstall) begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        pipe_hold     = 1'b1;
        mem_wb_bubble = 1'b1;
      end else if (hazard) begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_exe_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
`ifdef MEMSEQ_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      case (state)
        RUN: begin
          if (access && !dmem_ack) begin
            state <= WAIT_ACK;
`ifdef MEMSEQ_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        WAIT_ACK: begin
          if (dmem_ack) begin
            state <= RUN;
`ifdef MEMSEQ_TIMEOUT_EN
          // wait_cnt holds (WAIT_ACK cycle index - 1); ack in the last cycle takes priority.
          end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            state <= ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
`ifdef MEMSEQ_TIMEOUT_EN
        ERR: state <= ERR;
`endif
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall_clr) begin
      stall_count <= '0;
    end else if (!pc_write && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_stage_sequencer.sv
// Directed, table-driven bench for mem_stage_sequencer (CNT_W=4, TIMEOUT=4); timeout cases need MEMSEQ_TIMEOUT_EN.
module tb_mem_stage_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] if_id_rs, if_id_rt, id_exe_rt;
  logic       id_exe_memread, exe_mem_memread, exe_mem_memwrite, dmem_ack, stall_clr;
  logic       dmem_req, pc_write, if_id_write, id_exe_bubble, pipe_hold, mem_wb_bubble;
  logic [3:0] stall_count;
  logic       mem_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_sequencer #(.CNT_W(4), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .id_exe_memread(id_exe_memread), .id_exe_rt(id_exe_rt),
    .exe_mem_memread(exe_mem_memread), .exe_mem_memwrite(exe_mem_memwrite),
    .dmem_ack(dmem_ack), .stall_clr(stall_clr),
    .dmem_req(dmem_req), .pc_write(pc_write), .if_id_write(if_id_write),
    .id_exe_bubble(id_exe_bubble), .pipe_hold(pipe_hold), .mem_wb_bubble(mem_wb_bubble),
    .stall_count(stall_count), .mem_timeout(mem_timeout)
  );

  // exp = {dmem_req, pc_write, if_id_write, id_exe_bubble, pipe_hold, mem_wb_bubble}
  typedef struct {
    logic       idm;
    logic [4:0] irt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       mr;
    logic       mw;
    logic       ack;
    logic       clr;
    logic [5:0] exp;
    logic [3:0] ecnt;
  } vec_t;

  vec_t vecs [22];

  localparam logic [5:0] O_IDLE = 6'b011000;
  localparam logic [5:0] O_ACK  = 6'b111000;
  localparam logic [5:0] O_MST  = 6'b100011;
  localparam logic [5:0] O_HAZ  = 6'b000100;
  localparam logic [5:0] O_HACK = 6'b100100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic idm, input logic [4:0] irt, input logic [4:0] rs,
                       input logic [4:0] rt, input logic mr, input logic mw,
                       input logic ack, input logic clr);
    id_exe_memread   = idm;
    id_exe_rt        = irt;
    if_id_rs         = rs;
    if_id_rt         = rt;
    exe_mem_memread  = mr;
    exe_mem_memwrite = mw;
    dmem_ack         = ack;
    stall_clr        = clr;
  endtask

  function automatic logic [5:0] outs();
    return {dmem_req, pc_write, if_id_write, id_exe_bubble, pipe_hold, mem_wb_bubble};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            idm  irt    rs     rt     mr    mw    ack   clr   exp     cnt
    vecs[0]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE, 4'd0};
    vecs[1]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, O_ACK,  4'd0};
    vecs[2]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE, 4'd0};
    vecs[3]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_MST,  4'd0};
    vecs[4]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_MST,  4'd1};
    vecs[5]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, O_ACK,  4'd2};
    vecs[6]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE, 4'd2};
    vecs[7]  = '{1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_HAZ,  4'd2};
    vecs[8]  = '{1'b0, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE, 4'd3};
    vecs[9]  = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE, 4'd3};
    vecs[10] = '{1'b1, 5'd7, 5'd7, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, O_HAZ,  4'd3};
    vecs[11] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, O_IDLE, 4'd4};
    vecs[12] = '{1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_MST,  4'd0};
    vecs[13] = '{1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_MST,  4'd1};
    vecs[14] = '{1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, O_HACK, 4'd2};
    vecs[15] = '{1'b0, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE, 4'd3};
    vecs[16] = '{1'b1, 5'd3, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, O_HAZ,  4'd3};
    vecs[17] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE, 4'd0};
    vecs[18] = '{1'b1, 5'd4, 5'd5, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE, 4'd0};
    vecs[19] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, O_MST,  4'd0};
    vecs[20] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, O_ACK,  4'd0};
    vecs[21] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE, 4'd0};

    // Reset with a pending load: outputs must stay at reset values.
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #12;
    chk("reset_outs", 32'(outs()), 32'(O_IDLE));
    chk("reset_cnt", 32'(stall_count), 32'd0);
    chk("reset_timeout", 32'(mem_timeout), 32'd0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();

    foreach (vecs[i]) begin
      drive(vecs[i].idm, vecs[i].irt, vecs[i].rs, vecs[i].rt,
            vecs[i].mr, vecs[i].mw, vecs[i].ack, vecs[i].clr);
      @(negedge clk);
      chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_cnt", i), 32'(stall_count), 32'(vecs[i].ecnt));
      next_cycle();
    end

    // Long memory stall: counter saturates at 15.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) next_cycle();
    @(negedge clk);
    chk("sat_cnt", 32'(stall_count), 32'd15);
    chk("sat_hold", 32'(pipe_hold), 32'd1);
`ifdef MEMSEQ_TIMEOUT_EN
    chk("sat_timeout", 32'(mem_timeout), 32'd1);
`else
    chk("sat_timeout", 32'(mem_timeout), 32'd0);
`endif
    stall_clr = 1'b1;
    next_cycle();
    chk("clr_prio_cnt", 32'(stall_count), 32'd0);
    stall_clr = 1'b0;

    // Reset while the access is outstanding drops the request immediately.
    rst_n = 1'b0;
    #1;
    chk("midreset_outs", 32'(outs()), 32'(O_IDLE));
    chk("midreset_cnt", 32'(stall_count), 32'd0);
    chk("midreset_timeout", 32'(mem_timeout), 32'd0);
    exe_mem_memread = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", 32'(outs()), 32'(O_IDLE));
    next_cycle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("post_reset_zero_wait", 32'(outs()), 32'(O_ACK));
    next_cycle();

`ifdef MEMSEQ_TIMEOUT_EN
    // Ack in the 4th WAIT_ACK cycle wins over the timeout.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) next_cycle();
    dmem_ack = 1'b1;
    @(negedge clk);
    chk("to_late_ack", 32'(outs()), 32'(O_ACK));
    next_cycle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("to_late_ack_run", 32'(outs()), 32'(O_IDLE));
    chk("to_late_ack_flag", 32'(mem_timeout), 32'd0);
    next_cycle();

    // No ack: RUN request cycle, 4 WAIT_ACK cycles, then ERR.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("to_wait%0d", i), 32'(outs()), 32'(O_MST));
      next_cycle();
    end
    @(negedge clk);
    chk("to_err_outs", 32'(outs()), 32'b011);
    chk("to_err_flag", 32'(mem_timeout), 32'd1);
    next_cycle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("to_err_sticky", 32'(outs()), 32'b011);
    rst_n = 1'b0;
    #1;
    chk("to_err_reset", 32'(mem_timeout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
